// File: rtl/def.sv
`default_nettype none
// def: constants and FSM encoding shared by the fetch PC controller, D-stage NPC logic and CP0.
package def;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC   = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE = 32'h0000_3000;
  localparam logic [31:0] IMEM_TOP  = 32'h0000_6FFC;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } pc_state_e;
endpackage
`default_nettype wire

// File: rtl/f_adel_chk.sv
`default_nettype none
// f_adel_chk: flags an address that is not word-aligned or lies outside [BASE, TOP] (unsigned).
module f_adel_chk #(
  parameter int                 WIDTH = 32,
  parameter logic [WIDTH-1:0]   BASE  = 32'h0000_3000,
  parameter logic [WIDTH-1:0]   TOP   = 32'h0000_6FFC
) (
  input  logic [WIDTH-1:0] addr,
  output logic             adel
);
  assign adel = (addr[1:0] != 2'b00) | (addr < BASE) | (addr > TOP);
endmodule
`default_nettype wire

// File: rtl/f_pc_ctrl.sv
`default_nettype none
// f_pc_ctrl: F-stage PC register with exception/ERET/redirect priority, stall-time redirect
// buffering and fetch-address exception flagging.
module f_pc_ctrl
  import def::pc_state_e, def::RUN, def::PEND;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = def::RESET_PC,
  parameter logic [WIDTH-1:0] EXC_VEC   = def::EXC_VEC,
  parameter logic [WIDTH-1:0] IMEM_BASE = def::IMEM_BASE,
  parameter logic [WIDTH-1:0] IMEM_TOP  = def::IMEM_TOP,
  parameter int               STEP      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_pc,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic             redir_pending,
  output logic             f_adel
);
  pc_state_e        state, state_nxt;
  logic [WIDTH-1:0] pend_pc, pend_nxt, pc_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      state   <= RUN;
      pend_pc <= '0;
    end else begin
      pc      <= pc_nxt;
      state   <= state_nxt;
      pend_pc <= pend_nxt;
    end
  end

  // Exception and ERET override stall; leaving PEND for RUN discards any buffered target.
  always_comb begin
    pc_nxt    = pc + WIDTH'(STEP);
    state_nxt = state;
    pend_nxt  = pend_pc;
    if (exc_req) begin
      pc_nxt    = EXC_VEC;
      state_nxt = RUN;
    end else if (eret_req) begin
      pc_nxt    = epc;
      state_nxt = RUN;
    end else if (stall) begin
      pc_nxt = pc;
      if (redir_valid) begin
        pend_nxt  = redir_pc;
        state_nxt = PEND;
      end
    end else if (redir_valid) begin
      pc_nxt    = redir_pc;
      state_nxt = RUN;
    end else if (state == PEND) begin
      pc_nxt    = pend_pc;
      state_nxt = RUN;
    end
  end

  assign redir_pending = (state == PEND);

  f_adel_chk #(
    .WIDTH (WIDTH),
    .BASE  (IMEM_BASE),
    .TOP   (IMEM_TOP)
  ) u_adel_chk (
    .addr (pc),
    .adel (f_adel)
  );
endmodule
`default_nettype wire

// File: tb/tb_f_pc_ctrl.sv
`default_nettype none
// tb_f_pc_ctrl: directed vectors with hand-computed expected PC / pending / AdEL values.
module tb_f_pc_ctrl;
  logic        clk = 1'b0;
  logic        reset, stall, redir_valid, exc_req, eret_req;
  logic [31:0] redir_pc, epc, pc;
  logic        redir_pending, f_adel;

  logic        w_reset, w_redir_valid;
  logic [31:0] w_redir_pc, w_pc;
  logic        w_redir_pending, w_f_adel;

  int asserts  = 0;
  int failures = 0;

  always #5 clk = ~clk;

  f_pc_ctrl u_dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redir_valid   (redir_valid),
    .redir_pc      (redir_pc),
    .exc_req       (exc_req),
    .eret_req      (eret_req),
    .epc           (epc),
    .pc            (pc),
    .redir_pending (redir_pending),
    .f_adel        (f_adel)
  );

  f_pc_ctrl #(.IMEM_TOP(32'hFFFF_FFFC)) u_wrap (
    .clk           (clk),
    .reset         (w_reset),
    .stall         (1'b0),
    .redir_valid   (w_redir_valid),
    .redir_pc      (w_redir_pc),
    .exc_req       (1'b0),
    .eret_req      (1'b0),
    .epc           (32'h0),
    .pc            (w_pc),
    .redir_pending (w_redir_pending),
    .f_adel        (w_f_adel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    asserts++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [31:0] p, input logic pend, input logic adel);
    check({tag, ".pc"}, pc, p);
    check({tag, ".pend"}, {31'b0, redir_pending}, {31'b0, pend});
    check({tag, ".adel"}, {31'b0, f_adel}, {31'b0, adel});
  endtask

  initial begin
    reset = 1; stall = 0; redir_valid = 0; redir_pc = 0;
    exc_req = 0; eret_req = 0; epc = 0;
    w_reset = 1; w_redir_valid = 0; w_redir_pc = 0;

    tick(); tick();
    chk3("reset", 32'h3000, 0, 0);
    reset = 0;
    tick(); chk3("run1", 32'h3004, 0, 0);
    tick(); chk3("run2", 32'h3008, 0, 0);
    tick(); chk3("run3", 32'h300C, 0, 0);
    tick(); chk3("run4", 32'h3010, 0, 0);

    redir_valid = 1; redir_pc = 32'h3400;
    tick(); chk3("redir", 32'h3400, 0, 0);
    redir_valid = 0;
    tick(); chk3("redir_seq", 32'h3404, 0, 0);

    redir_valid = 1; redir_pc = 32'h3010;
    tick(); chk3("to3010", 32'h3010, 0, 0);

    stall = 1; redir_pc = 32'h3500;
    tick(); chk3("stall1", 32'h3010, 1, 0);
    redir_pc = 32'h3600;
    tick(); chk3("stall2", 32'h3010, 1, 0);
    redir_valid = 0;
    tick(); chk3("stall3", 32'h3010, 1, 0);
    stall = 0;
    tick(); chk3("pend_apply", 32'h3600, 0, 0);
    tick(); chk3("pend_once", 32'h3604, 0, 0);

    stall = 1; redir_valid = 1; redir_pc = 32'h3700;
    tick(); chk3("pend_again", 32'h3604, 1, 0);
    redir_valid = 0; exc_req = 1; eret_req = 1; epc = 32'h3014;
    tick(); chk3("exc_win", 32'h4180, 0, 0);
    exc_req = 0; eret_req = 0;
    tick(); chk3("stall_hold", 32'h4180, 0, 0);
    stall = 0;
    tick(); chk3("no_stale", 32'h4184, 0, 0);
    eret_req = 1;
    tick(); chk3("eret", 32'h3014, 0, 0);
    epc = 32'h3002;
    tick(); chk3("adel_misal", 32'h3002, 0, 1);
    eret_req = 0; redir_valid = 1; redir_pc = 32'h2FFC;
    tick(); chk3("adel_low", 32'h2FFC, 0, 1);
    redir_pc = 32'h6FFC;
    tick(); chk3("adel_top", 32'h6FFC, 0, 0);
    redir_valid = 0;
    tick(); chk3("adel_high", 32'h7000, 0, 1);

    stall = 1; redir_valid = 1; redir_pc = 32'h3800;
    tick(); chk3("pend_rst", 32'h7000, 1, 1);
    redir_valid = 0; reset = 1;
    tick(); chk3("mid_rst", 32'h3000, 0, 0);
    reset = 0; stall = 0;
    tick(); chk3("post_rst", 32'h3004, 0, 0);

    w_reset = 0; w_redir_valid = 1; w_redir_pc = 32'hFFFF_FFFC;
    tick();
    check("wrap.pc0", w_pc, 32'hFFFF_FFFC);
    check("wrap.adel0", {31'b0, w_f_adel}, 32'h0);
    w_redir_valid = 0;
    tick();
    check("wrap.pc1", w_pc, 32'h0000_0000);
    check("wrap.adel1", {31'b0, w_f_adel}, 32'h1);
    check("wrap.pend", {31'b0, w_redir_pending}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
`default_nettype wire
